spi_target: RTL

SPI_TARGET -- requirements
Module: spi_target

---
 rtl/spi_pkg.sv | 16 +
 rtl/sync2.sv | 26 ++
 rtl/spi_target.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target: state encoding, byte geometry and the
// default byte driven on miso when the host has nothing queued.
package spi_pkg;

  typedef enum logic {
    DESELECTED = 1'b0,
    SELECTED   = 1'b1
  } spi_state_t;

  localparam int BITS_PER_BYTE = 8;
  localparam int CNT_W         = $clog2(BITS_PER_BYTE);

  localparam logic [CNT_W-1:0]         LAST_BIT          = CNT_W'(BITS_PER_BYTE - 1);
  localparam logic [BITS_PER_BYTE-1:0] IDLE_BYTE_DEFAULT = 8'hFF;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous pin; the reset value lets idle-high
// pins such as cs_n come out of reset in their inactive level.
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: flops use <= so both stages sample the old values on the same edge;
  // a blocking = here would collapse the chain into a single flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target oversampled by clk: pins are synchronized, sck edges detected
// against a registered copy, and one byte of rx and one byte of tx are buffered.
module spi_target
  import spi_pkg::*;
#(
  parameter logic [BITS_PER_BYTE-1:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sck,
  input  logic                     cs_n,
  input  logic                     mosi,
  output logic                     miso,
  output logic                     miso_oe,
  output logic [BITS_PER_BYTE-1:0] rx_data,
  output logic                     rx_valid,
  input  logic                     rx_rd,
  output logic                     rx_overrun,
  input  logic [BITS_PER_BYTE-1:0] tx_data,
  input  logic                     tx_wr,
  output logic                     tx_full
);

  logic sck_s, cs_n_s, mosi_s, sck_d;

  sync2 #(.RESET_VAL(1'b0)) u_sync_sck  (.clk(clk), .reset(reset), .d(sck),  .q(sck_s));
  sync2 #(.RESET_VAL(1'b1)) u_sync_cs_n (.clk(clk), .reset(reset), .d(cs_n), .q(cs_n_s));
  sync2 #(.RESET_VAL(1'b0)) u_sync_mosi (.clk(clk), .reset(reset), .d(mosi), .q(mosi_s));

  spi_state_t               state,      state_next;
  logic [CNT_W-1:0]         bit_cnt,    bit_cnt_next;
  // Bit 7 of an incoming byte never needs storing: it leaves on the completing rise.
  logic [BITS_PER_BYTE-2:0] rx_shift,   rx_shift_next;
  logic [BITS_PER_BYTE-1:0] tx_shift,   tx_shift_next;
  logic [BITS_PER_BYTE-1:0] tx_hold,    tx_hold_next;
  logic [BITS_PER_BYTE-1:0] rx_data_next;
  logic                     tx_full_next, rx_valid_next, rx_overrun_next;

  logic sck_rise, sck_fall, load, byte_done;
  logic [BITS_PER_BYTE-1:0] rx_byte;

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign rx_byte  = {rx_shift, mosi_s};

  // NOTE: every variable gets its hold value first so no path through the
  // case/if tree leaves one unassigned, which would infer a latch.
  always_comb begin
    state_next      = state;
    bit_cnt_next    = bit_cnt;
    rx_shift_next   = rx_shift;
    tx_shift_next   = tx_shift;
    tx_hold_next    = tx_hold;
    tx_full_next    = tx_full;
    rx_data_next    = rx_data;
    rx_valid_next   = rx_valid;
    rx_overrun_next = rx_overrun;
    load            = 1'b0;
    byte_done       = 1'b0;

    unique case (state)
      DESELECTED: begin
        bit_cnt_next = '0;
        if (!cs_n_s) begin
          state_next = SELECTED;
          load       = 1'b1;
        end
      end
      SELECTED: begin
        // A rise is processed even when cs_n goes high in the same cycle, so a
        // byte finishing together with deselect is still delivered.
        if (sck_rise) begin
          rx_shift_next = rx_byte[BITS_PER_BYTE-2:0];
          bit_cnt_next  = bit_cnt + CNT_W'(1);
          byte_done     = (bit_cnt == LAST_BIT);
        end
        if (cs_n_s) begin
          state_next    = DESELECTED;
          bit_cnt_next  = '0;
          rx_shift_next = '0;
        end else if (sck_fall) begin
          if (bit_cnt == '0) begin
            load = 1'b1;
          end else begin
            tx_shift_next = {tx_shift[BITS_PER_BYTE-2:0], 1'b0};
          end
        end
      end
    endcase

    // A write landing on an empty holding register during a load stays queued;
    // the load itself already committed to IDLE_BYTE.
    if (load) begin
      tx_shift_next = tx_full ? tx_hold : IDLE_BYTE;
      tx_full_next  = 1'b0;
    end
    if (tx_wr && !tx_full) begin
      tx_hold_next = tx_data;
      tx_full_next = 1'b1;
    end

    if (byte_done) begin
      rx_data_next    = rx_byte;
      rx_valid_next   = 1'b1;
      rx_overrun_next = rx_rd ? 1'b0 : (rx_overrun | rx_valid);
    end else if (rx_rd) begin
      rx_valid_next   = 1'b0;
      rx_overrun_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= DESELECTED;
      sck_d      <= 1'b0;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= IDLE_BYTE;
      tx_hold    <= '0;
      tx_full    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      state      <= state_next;
      sck_d      <= sck_s;
      bit_cnt    <= bit_cnt_next;
      rx_shift   <= rx_shift_next;
      tx_shift   <= tx_shift_next;
      tx_hold    <= tx_hold_next;
      tx_full    <= tx_full_next;
      rx_data    <= rx_data_next;
      rx_valid   <= rx_valid_next;
      rx_overrun <= rx_overrun_next;
    end
  end

  assign miso    = tx_shift[BITS_PER_BYTE-1];
  assign miso_oe = (state == SELECTED);

endmodule
